// File: rtl/psum_drain_ctrl_pkg.sv
// Shared definitions for the systolic drain path: the drain FSM state type,
// the output row index width and the default array geometry.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    ISSUE = 3'd2,
    FLUSH = 3'd3,
    FIN   = 3'd4
  } drain_state_t;

  localparam int ROW_IDX_W      = 6;
  localparam int DEF_COL        = 32;
  localparam int DEF_DW         = 16;
  localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/psum_drain_ctrl_if.sv
// Aligned-row handshake between the drain controller and the output buffer.
interface psum_drain_ctrl_if #(
  parameter int COL = 32,
  parameter int DW  = 16
);
  logic                 out_valid;
  logic                 out_ready;
  logic [COL*DW-1:0]    out_data;
  logic [5:0]           out_row;

  modport master (output out_valid, output out_data, output out_row, input out_ready);
  modport slave  (input out_valid, input out_data, input out_row, output out_ready);
endinterface

// File: rtl/psum_drain_ctrl_row_fifo.sv
// First-word-fall-through FIFO for aligned rows. A push while full is only
// accepted when a pop happens in the same cycle; the caller detects drops.
module row_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push_s;
  logic          do_pop_s;

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);
  assign rdata_o   = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage array; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/psum_drain_ctrl.sv
// Drain controller for the systolic array bottom edge: drives the skewed
// out_en wavefront, de-skews captured psums into whole rows and hands them to
// the output buffer through a small FWFT FIFO.
// Optional build macro PSUM_DRAIN_RELU_EN: zero negative elements at FIFO push.
module psum_drain_ctrl
  import systolic_pkg::*;
#(
  parameter int COL        = DEF_COL,
  parameter int DW         = DEF_DW,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [5:0]           n_rows_i,
  input  logic [5:0]           start_delay_i,
  input  logic [COL*DW-1:0]    psum_in_i,
  output logic [COL-1:0]       out_en_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 overflow_o,
  psum_drain_ctrl_if.master    out_if
);
  localparam int RW = COL*DW;

  drain_state_t          state_q, state_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [5:0]            n_rows_q, n_rows_d;
  logic [COL-1:0]        out_en_q, out_en_d;
  logic                  busy_q, done_q, ovf_q, ovf_d;
  logic [ROW_IDX_W-1:0]  push_cnt_q;
  logic                  start_acc_s;
  logic                  push_s, pop_s, drop_s;
  logic                  fifo_full_s, fifo_empty_s;
  logic [RW-1:0]         row_s, push_data_s;
  logic [RW+ROW_IDX_W-1:0] fifo_rdata_s;

  // Next-state logic. The counter is loaded one below the programmed value so
  // that ISSUE starts exactly start_delay+1 cycles after the start edge and
  // lasts exactly n_rows cycles.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_rows_d    = n_rows_q;
    start_acc_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          start_acc_s = 1'b1;
          n_rows_d    = n_rows_i;
          if (n_rows_i == 6'd0) begin
            state_d = FIN;
          end else if (start_delay_i == 6'd0) begin
            state_d = ISSUE;
            cnt_d   = n_rows_i - 6'd1;
          end else begin
            state_d = WAIT;
            cnt_d   = start_delay_i - 6'd1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 6'd0) begin
          state_d = ISSUE;
          cnt_d   = n_rows_q - 6'd1;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      ISSUE: begin
        if (cnt_q == 6'd0) begin
          state_d = FLUSH;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      FLUSH: begin
        if ((out_en_q == '0) && fifo_empty_s) begin
          state_d = FIN;
        end else begin
          state_d = FLUSH;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Wavefront: bit 0 tracks the ISSUE state, higher columns follow one cycle later each.
  assign out_en_d = {out_en_q[COL-2:0], (state_d == ISSUE)};

  assign push_s = out_en_q[COL-1];
  assign pop_s  = out_if.out_valid && out_if.out_ready;
  assign drop_s = push_s && fifo_full_s && !pop_s;
  assign ovf_d  = start_acc_s ? 1'b0 : (ovf_q | drop_s);

  // Control registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      n_rows_q   <= '0;
      out_en_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      push_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_rows_q   <= n_rows_d;
      out_en_q   <= out_en_d;
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == FIN);
      ovf_q      <= ovf_d;
      if (start_acc_s) begin
        push_cnt_q <= '0;
      end else if (push_s) begin
        push_cnt_q <= push_cnt_q + 6'd1;
      end else begin
        push_cnt_q <= push_cnt_q;
      end
    end
  end

  // De-skew triangle: column j is captured under out_en[j] and then delayed so
  // that every column of a row reaches the FIFO input in the cycle the last
  // column is on the bus. The last column is taken straight from the array.
  for (genvar j = 0; j < COL; j++) begin : g_col
    if (j == COL-1) begin : g_last
      assign row_s[j*DW +: DW] = psum_in_i[j*DW +: DW];
    end else begin : g_dly
      localparam int L = COL-1-j;
      logic [DW-1:0] dly_q [L];

      // Capture stage gated by the column enable, remaining stages free-running.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < L; i++) dly_q[i] <= '0;
        end else begin
          if (out_en_q[j]) dly_q[0] <= psum_in_i[j*DW +: DW];
          for (int i = 1; i < L; i++) dly_q[i] <= dly_q[i-1];
        end
      end

      assign row_s[j*DW +: DW] = dly_q[L-1];
    end
  end

`ifdef PSUM_DRAIN_RELU_EN
  for (genvar j = 0; j < COL; j++) begin : g_relu
    assign push_data_s[j*DW +: DW] = row_s[j*DW+DW-1] ? '0 : row_s[j*DW +: DW];
  end
`else
  assign push_data_s = row_s;
`endif

  row_fifo #(
    .W     (RW + ROW_IDX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_row_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .wdata_i ({push_cnt_q, push_data_s}),
    .pop_i   (pop_s),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign out_if.out_valid = !fifo_empty_s;
  assign out_if.out_data  = fifo_empty_s ? '0 : fifo_rdata_s[RW-1:0];
  assign out_if.out_row   = fifo_empty_s ? '0 : fifo_rdata_s[RW +: ROW_IDX_W];

  assign out_en_o   = out_en_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign overflow_o = ovf_q;
endmodule

// File: doc/psum_drain_ctrl.md
Name: psum_drain_ctrl

Overview:
- Output-side counterpart of the systolic convolution controller.
- The input side feeds rows into the array. This block drains the array's bottom edge:
  - drives the skewed per-column out_en wavefront;
  - captures each column's partial sums and de-skews them into whole output rows;
  - hands rows to the output buffer over a valid/ready interface, with a small FIFO absorbing backpressure.
- Sits between the systolic array's bottom row and the output buffer writer.

Parameters:
- COL, 32, number of array columns (one psum per column per row)
- DW, 16, partial-sum width (signed two's complement)
- FIFO_DEPTH, 4, aligned-row FIFO entries (power of two, >=2)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- n_rows  in  6  output rows to drain; latched on start
- start_delay  in  6  cycles from start to the first column-0 capture; latched on start
- psum_in  in  COL*DW  bottom-edge psums; column j = bits [j*DW +: DW]
- out_en  out  COL  per-column capture enable to the array
- out_valid  out  1  aligned row available
- out_ready  in  1  downstream accepts the row
- out_data  out  COL*DW  aligned row, same column packing as psum_in
- out_row  out  6  index of the row on out_data (0..n_rows-1)
- busy  out  1  drain in progress
- done  out  1  one-cycle pulse after the last row has been accepted
- overflow  out  1  sticky: a row was dropped because the FIFO was full

Behaviour:
- Reset:
  - All outputs are 0; FSM goes to IDLE; FIFO is emptied; counters are 0.
  - Reset mid-operation aborts the drain immediately. No done pulse is produced.
- FSM states: IDLE, WAIT, ISSUE, FLUSH, FIN.
  - IDLE -> WAIT on start; n_rows and start_delay are latched. start outside IDLE is ignored.
  - IDLE -> FIN directly if start arrives with n_rows==0.
  - WAIT: delay counter loaded with start_delay, counts down. Moves to ISSUE when the counter is 0, so ISSUE begins cycle S = start_delay+1 after the start edge.
  - ISSUE: issue=1 for exactly n_rows cycles (S..S+N-1), then FLUSH.
  - FLUSH: waits until the wavefront shift register is 0 and the FIFO is empty, then FIN.
  - FIN: done=1 for one cycle, then IDLE.
- Wavefront:
  - out_en is a COL-bit shift register, next = {out_en[COL-2:0], issue}.
  - out_en[j] is high in cycles S+j .. S+j+N-1.
  - psum_in column j is sampled at the end of every cycle in which out_en[j]=1.
- De-skew:
  - Column j passes through COL-1-j delay registers, so row k's columns align at the end of cycle S+k+COL-1.
  - The aligned row is pushed into the FIFO when the delayed out_en[COL-1] is high.
  - out_row comes from a 6-bit push counter, stored alongside the data.
- FIFO:
  - First-word-fall-through; out_valid = !empty.
  - With an empty FIFO, row k appears with out_valid high in cycle S+k+COL.
  - Pop when out_valid && out_ready. out_data and out_row hold stable while out_valid && !out_ready.
  - Push and pop in the same cycle while full: both succeed.
  - Push while full with no pop: the row is dropped, overflow is set, and the push counter still increments.
  - overflow clears only on rst or an accepted start.
- busy: high from the cycle after start through the FIN cycle; low in IDLE.
- Width: psums pass through unmodified, with no sign extension or truncation (except under the optional feature below).

Optional Feature:
- Macro: PSUM_DRAIN_RELU_EN
- Defined: each DW-bit element is replaced by 0 if its MSB is 1 (ReLU), applied at FIFO push. Adds no latency.
- Undefined: data passes through unchanged; no ReLU logic is instantiated.

Decomposition:
- Shared package (systolic_pkg):
  - drain_state_t enum {IDLE, WAIT, ISSUE, FLUSH, FIN};
  - ROW_IDX_W = 6;
  - default COL/DW constants shared with the convolution controller.
- Sub-module row_fifo: parameterised FWFT FIFO (width COL*DW+6, depth FIFO_DEPTH) with full/empty flags.
- The de-skew triangle stays inline as a generate loop.

Test Plan (COL=4, DW=16, FIFO_DEPTH=2 unless noted):
- Basic drain: start, n_rows=3, start_delay=2, out_ready=1, column j at cycle t = 100*k+j.
  - out_en[0] high in cycles 3-5, out_en[3] high in cycles 6-8.
  - Rows {0,1,2,3}, {100..103}, {200..203} appear with out_valid in cycles 7, 8, 9, out_row = 0, 1, 2.
  - done in cycle 11.
- Backpressure: as above, with out_ready=0 until cycle 12.
  - Rows 0 and 1 are held stable; row 2 is dropped and overflow=1.
  - After out_ready rises, rows 0 and 1 pop and done pulses.
- Full with simultaneous push/pop: FIFO full, out_ready=1 on the push cycle.
  - No drop; overflow stays 0.
- Zero rows: start with n_rows=0.
  - out_en stays 0, no out_valid; done in cycle 1, busy high only in cycle 1.
- Mid-run reset and ignored start:
  - rst asserted during ISSUE: all outputs are 0 next cycle, no done, FIFO empty.
  - start pulsed during WAIT has no effect on the latched n_rows.
- PSUM_DRAIN_RELU_EN: input column value 16'h8001 -> out_data element 0; 16'h7FFF -> passes unchanged.
